// File: rtl/noc_qsys_debug_ocimem_arbiter_if.sv
// ---------------------------------------------------------------------------
// noc_qsys_debug_ocimem_arbiter_if
//
// Bundles every non-clock, non-reset signal of the OCI debug memory arbiter:
// the JTAG command strobes and monitor outputs, the CPU debug-slave
// Avalon-MM port, and the single-port OCI RAM port.
//
// Modports:
//   slave  - the arbiter itself: consumes JTAG/CPU requests and RAM read
//            data, produces monitor data, Avalon responses and RAM controls.
//   master - the surrounding environment (debug slave wrapper, CPU port and
//            RAM instance, or a testbench standing in for all three).
//
// Signal groups:
//   JTAG : jdo[37:0], take_action_ocimem_a, take_no_action_ocimem_a,
//          take_action_ocimem_b -> MonDReg[31:0], monitor_ready, jtag_busy,
//          jtag_overrun
//   CPU  : cpu_address, cpu_read, cpu_write, cpu_writedata, cpu_byteenable
//          -> cpu_waitrequest, cpu_readdata, cpu_readdatavalid
//   RAM  : ram_cs, ram_we, ram_addr, ram_wdata, ram_be <- ram_rdata
// ---------------------------------------------------------------------------
interface noc_qsys_debug_ocimem_arbiter_if #(
    parameter int ADDR_W = 8
);
    // JTAG debug-slave command path, already in the system clock domain
    logic [37:0]       jdo;
    logic              take_action_ocimem_a;
    logic              take_no_action_ocimem_a;
    logic              take_action_ocimem_b;
    logic [31:0]       MonDReg;
    logic              monitor_ready;
    logic              jtag_busy;
    logic              jtag_overrun;

    // CPU debug-slave Avalon-MM port
    logic [ADDR_W-1:0] cpu_address;
    logic              cpu_read;
    logic              cpu_write;
    logic [31:0]       cpu_writedata;
    logic [3:0]        cpu_byteenable;
    logic              cpu_waitrequest;
    logic [31:0]       cpu_readdata;
    logic              cpu_readdatavalid;

    // OCI RAM port
    logic              ram_cs;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [3:0]        ram_be;
    logic [31:0]       ram_rdata;

    modport slave (
        input  jdo, take_action_ocimem_a, take_no_action_ocimem_a,
               take_action_ocimem_b,
        output MonDReg, monitor_ready, jtag_busy, jtag_overrun,
        input  cpu_address, cpu_read, cpu_write, cpu_writedata, cpu_byteenable,
        output cpu_waitrequest, cpu_readdata, cpu_readdatavalid,
        output ram_cs, ram_we, ram_addr, ram_wdata, ram_be,
        input  ram_rdata
    );

    modport master (
        output jdo, take_action_ocimem_a, take_no_action_ocimem_a,
               take_action_ocimem_b,
        input  MonDReg, monitor_ready, jtag_busy, jtag_overrun,
        output cpu_address, cpu_read, cpu_write, cpu_writedata, cpu_byteenable,
        input  cpu_waitrequest, cpu_readdata, cpu_readdatavalid,
        input  ram_cs, ram_we, ram_addr, ram_wdata, ram_be,
        output ram_rdata
    );
endinterface

// File: rtl/noc_qsys_debug_ocimem_arbiter.sv
// ---------------------------------------------------------------------------
// noc_qsys_debug_ocimem_arbiter
//
// Shares the single-port Nios II OCI debug RAM between the JTAG debug-slave
// path and the CPU debug-slave Avalon-MM port. Requests are arbitrated
// round-robin, each access is sequenced as IDLE -> ACC (-> RD for reads),
// read data is returned to the winner, and the JTAG address post-increments
// after every completed JTAG access.
//
// Parameters:
//   ADDR_W - OCI RAM word-address width (default 8, 256 words).
//
// Ports:
//   clk    - system clock, the only clock.
//   reset  - synchronous, active-high reset.
//   bus    - slave modport of noc_qsys_debug_ocimem_arbiter_if carrying the
//            JTAG strobes/monitor, CPU Avalon port and OCI RAM port.
//
// Behaviour summary:
//   - JTAG strobes: address load, read, write. Any strobe seen while a JTAG
//     access is pending or in flight is dropped and sets jtag_overrun.
//   - Arbitration happens only in IDLE; on a tie the requester that did not
//     win last time gets the grant (JTAG is treated as last after reset).
//   - cpu_waitrequest is combinational and drops only in the IDLE cycle in
//     which the CPU is granted.
//   - All RAM controls are registered; ram_cs is high for exactly the ACC
//     cycle, and ram_rdata is captured in the following RD cycle.
// ---------------------------------------------------------------------------
module noc_qsys_debug_ocimem_arbiter #(
    parameter int ADDR_W = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    noc_qsys_debug_ocimem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_RD   = 2'd2
    } state_t;

    typedef enum logic {
        REQ_JTAG = 1'b0,
        REQ_CPU  = 1'b1
    } req_t;

    state_t            state;
    state_t            state_next;

    // Arbitration bookkeeping and the owner of the access in flight
    req_t              last_grant;
    req_t              owner;
    logic              owner_read;

    // Pending JTAG access (one deep: a second strobe is an overrun)
    logic              jtag_pend;
    logic              jtag_pend_we;
    logic [31:0]       jtag_pend_wdata;
    logic [ADDR_W-1:0] jtag_addr;

    // Registered outputs
    logic              jtag_overrun_q;
    logic              monitor_ready_q;
    logic [31:0]       mon_dreg_q;
    logic [31:0]       cpu_readdata_q;
    logic              cpu_rdv_q;
    logic              ram_cs_q;
    logic              ram_we_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [31:0]       ram_wdata_q;
    logic [3:0]        ram_be_q;

    // Combinational helpers
    logic              cpu_req;
    logic              cpu_is_write;
    logic              jtag_strobe;
    logic              jtag_busy_w;
    logic              grant_cpu;
    logic              grant_jtag;
    logic              jdo_unused;

    // Only the address field and the write-data field of jdo carry meaning
    // here; the remaining bits belong to other OCI command decoders.
    assign jdo_unused   = ^{bus.jdo[37:35], bus.jdo[2:0]};

    // A CPU transfer with both read and write high is handled as a write.
    assign cpu_req      = bus.cpu_read | bus.cpu_write;
    assign cpu_is_write = bus.cpu_write;

    assign jtag_strobe  = bus.take_action_ocimem_a
                        | bus.take_no_action_ocimem_a
                        | bus.take_action_ocimem_b;

    // JTAG is busy from the cycle after its strobe until the FSM is back in
    // IDLE after serving it; derived purely from registered state so that it
    // rises one cycle after the strobe and falls on the return to IDLE.
    assign jtag_busy_w  = jtag_pend | ((state != ST_IDLE) && (owner == REQ_JTAG));

    // Round-robin arbitration and next-state selection. Grants are only
    // issued in IDLE; on a tie the requester not named by last_grant wins.
    // ACC branches to RD for reads and straight back to IDLE for writes.
    always_comb begin
        grant_cpu  = 1'b0;
        grant_jtag = 1'b0;
        state_next = state;

        if (state == ST_IDLE) begin
            if (cpu_req && jtag_pend) begin
                if (last_grant == REQ_JTAG) begin
                    grant_cpu = 1'b1;
                end else begin
                    grant_jtag = 1'b1;
                end
            end else if (cpu_req) begin
                grant_cpu = 1'b1;
            end else if (jtag_pend) begin
                grant_jtag = 1'b1;
            end
        end

        case (state)
            ST_IDLE: begin
                if (grant_cpu || grant_jtag) begin
                    state_next = ST_ACC;
                end
            end
            ST_ACC: begin
                state_next = owner_read ? ST_RD : ST_IDLE;
            end
            ST_RD: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // FSM state register; reset abandons any access in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Datapath: JTAG command decode, grant loading of the RAM controls,
    // JTAG address post-increment and read-data return.
    //
    // The JTAG strobe decode never collides with the grant/increment/return
    // updates below: those only touch JTAG state while jtag_busy is high,
    // and a strobe arriving while busy is dropped (only the overrun flag
    // is touched).
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant      <= REQ_JTAG;
            owner           <= REQ_JTAG;
            owner_read      <= 1'b0;
            jtag_pend       <= 1'b0;
            jtag_pend_we    <= 1'b0;
            jtag_pend_wdata <= '0;
            jtag_addr       <= '0;
            jtag_overrun_q  <= 1'b0;
            monitor_ready_q <= 1'b0;
            mon_dreg_q      <= '0;
            cpu_readdata_q  <= '0;
            cpu_rdv_q       <= 1'b0;
            ram_cs_q        <= 1'b0;
            ram_we_q        <= 1'b0;
            ram_addr_q      <= '0;
            ram_wdata_q     <= '0;
            ram_be_q        <= '0;
        end else begin
            // Single-cycle pulses fall back by default
            ram_cs_q  <= 1'b0;
            ram_we_q  <= 1'b0;
            cpu_rdv_q <= 1'b0;

            if (jtag_strobe) begin
                if (jtag_busy_w) begin
                    jtag_overrun_q <= 1'b1;
                end else if (bus.take_action_ocimem_a) begin
                    jtag_addr       <= bus.jdo[ADDR_W+16:17];
                    monitor_ready_q <= 1'b0;
                end else if (bus.take_no_action_ocimem_a) begin
                    jtag_pend       <= 1'b1;
                    jtag_pend_we    <= 1'b0;
                    monitor_ready_q <= 1'b0;
                end else begin
                    jtag_pend       <= 1'b1;
                    jtag_pend_we    <= 1'b1;
                    jtag_pend_wdata <= bus.jdo[34:3];
                end
            end

            if (grant_cpu) begin
                last_grant  <= REQ_CPU;
                owner       <= REQ_CPU;
                owner_read  <= ~cpu_is_write;
                ram_cs_q    <= 1'b1;
                ram_we_q    <= cpu_is_write;
                ram_addr_q  <= bus.cpu_address;
                ram_wdata_q <= bus.cpu_writedata;
                ram_be_q    <= bus.cpu_byteenable;
            end else if (grant_jtag) begin
                last_grant  <= REQ_JTAG;
                owner       <= REQ_JTAG;
                owner_read  <= ~jtag_pend_we;
                jtag_pend   <= 1'b0;
                ram_cs_q    <= 1'b1;
                ram_we_q    <= jtag_pend_we;
                ram_addr_q  <= jtag_addr;
                ram_wdata_q <= jtag_pend_wdata;
                ram_be_q    <= 4'hF;
            end

            // A JTAG write is complete once the RAM has seen it in ACC
            if ((state == ST_ACC) && !owner_read && (owner == REQ_JTAG)) begin
                jtag_addr <= jtag_addr + ADDR_W'(1);
            end

            // RD: ram_rdata now holds the word addressed during ACC
            if (state == ST_RD) begin
                if (owner == REQ_CPU) begin
                    cpu_readdata_q <= bus.ram_rdata;
                    cpu_rdv_q      <= 1'b1;
                end else begin
                    mon_dreg_q      <= bus.ram_rdata;
                    monitor_ready_q <= 1'b1;
                    jtag_addr       <= jtag_addr + ADDR_W'(1);
                end
            end
        end
    end

    // Waitrequest is held high throughout reset and otherwise drops only
    // in the IDLE cycle where the CPU is the winner.
    assign bus.cpu_waitrequest   = reset | ~grant_cpu;
    assign bus.cpu_readdata      = cpu_readdata_q;
    assign bus.cpu_readdatavalid = cpu_rdv_q;

    assign bus.MonDReg           = mon_dreg_q;
    assign bus.monitor_ready     = monitor_ready_q;
    assign bus.jtag_busy         = jtag_busy_w;
    assign bus.jtag_overrun      = jtag_overrun_q;

    assign bus.ram_cs            = ram_cs_q;
    assign bus.ram_we            = ram_we_q;
    assign bus.ram_addr          = ram_addr_q;
    assign bus.ram_wdata         = ram_wdata_q;
    assign bus.ram_be            = ram_be_q;

endmodule

// File: tb/tb_noc_qsys_debug_ocimem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_noc_qsys_debug_ocimem_arbiter
//
// Self-checking bench for noc_qsys_debug_ocimem_arbiter. The bench plays the
// OCI RAM (synchronous read, byte-enabled write) and keeps a transaction
// level reference: a word array for memory contents and a modulo-256 JTAG
// address. Directed scenarios cover reset, tie-breaking, the JTAG wrap and
// overrun; a randomized phase then mixes CPU and JTAG transactions.
// ---------------------------------------------------------------------------
module tb_noc_qsys_debug_ocimem_arbiter;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 1 << ADDR_W;

    logic clk = 1'b0;
    logic reset;
    logic ram_clear;

    always #5 clk = ~clk;

    noc_qsys_debug_ocimem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

    noc_qsys_debug_ocimem_arbiter #(.ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Stand-in for the OCI RAM instance: one-cycle read latency, byte
    // enables on write, and a log of every write the arbiter issues.
    logic [31:0]       ram_mem [DEPTH];
    int                ram_wr_count = 0;
    logic [ADDR_W-1:0] wlog_addr [$];
    logic [31:0]       wlog_data [$];

    always @(posedge clk) begin
        if (ram_clear) begin
            for (int i = 0; i < DEPTH; i++) ram_mem[i] <= '0;
        end else if (bus.ram_cs) begin
            if (bus.ram_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (bus.ram_be[b]) ram_mem[bus.ram_addr][8*b +: 8] <= bus.ram_wdata[8*b +: 8];
                end
                ram_wr_count <= ram_wr_count + 1;
                wlog_addr.push_back(bus.ram_addr);
                wlog_data.push_back(bus.ram_wdata);
            end else begin
                bus.ram_rdata <= ram_mem[bus.ram_addr];
            end
        end
    end

    // Reference model state
    logic [31:0]       ref_mem [DEPTH];
    logic [ADDR_W-1:0] model_jaddr;

    int vectors     = 0;
    int miscompares = 0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [37:0] randJdo();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[37:0];
    endfunction

    task automatic applyStimulus(input logic [37:0] jdo, input logic act_a, input logic noact_a,
                                 input logic act_b, input logic [ADDR_W-1:0] addr, input logic rd,
                                 input logic wr, input logic [31:0] wdata, input logic [3:0] be);
        bus.jdo                     = jdo;
        bus.take_action_ocimem_a    = act_a;
        bus.take_no_action_ocimem_a = noact_a;
        bus.take_action_ocimem_b    = act_b;
        bus.cpu_address             = addr;
        bus.cpu_read                = rd;
        bus.cpu_write               = wr;
        bus.cpu_writedata           = wdata;
        bus.cpu_byteenable          = be;
    endtask

    task automatic driveIdle();
        applyStimulus(randJdo(), 1'b0, 1'b0, 1'b0, ADDR_W'($urandom), 1'b0, 1'b0, $urandom, 4'($urandom));
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_waitreq"}, 32'(bus.cpu_waitrequest), 32'd1);
        checkOutput({tag, "_ram_cs"}, 32'(bus.ram_cs), 32'd0);
        checkOutput({tag, "_ram_we"}, 32'(bus.ram_we), 32'd0);
        checkOutput({tag, "_ram_addr"}, 32'(bus.ram_addr), 32'd0);
        checkOutput({tag, "_ram_wdata"}, bus.ram_wdata, 32'd0);
        checkOutput({tag, "_ram_be"}, 32'(bus.ram_be), 32'd0);
        checkOutput({tag, "_mondreg"}, bus.MonDReg, 32'd0);
        checkOutput({tag, "_mrdy"}, 32'(bus.monitor_ready), 32'd0);
        checkOutput({tag, "_busy"}, 32'(bus.jtag_busy), 32'd0);
        checkOutput({tag, "_overrun"}, 32'(bus.jtag_overrun), 32'd0);
        checkOutput({tag, "_rdata"}, bus.cpu_readdata, 32'd0);
        checkOutput({tag, "_rdv"}, 32'(bus.cpu_readdatavalid), 32'd0);
    endtask

    // Holds the current request until waitrequest drops; returns in the
    // cycle after acceptance.
    task automatic waitAccept(input string tag);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 20 && !ok; n++) begin
            #1;
            if (!bus.cpu_waitrequest) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        checkOutput({tag, "_accept"}, 32'(ok), 32'd1);
    endtask

    task automatic cpuWrite(input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic [3:0] be,
                            input bit both);
        applyStimulus(randJdo(), 1'b0, 1'b0, 1'b0, a, both, 1'b1, d, be);
        waitAccept("cpu_wr");
        driveIdle();
        checkOutput("cpu_wr_cs_we", 32'({bus.ram_cs, bus.ram_we}), 32'd3);
        checkOutput("cpu_wr_addr", 32'(bus.ram_addr), 32'(a));
        checkOutput("cpu_wr_be", 32'(bus.ram_be), 32'(be));
        for (int b = 0; b < 4; b++) begin
            if (be[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
        end
        stepCycle();
        checkOutput("cpu_wr_no_rdv_a", 32'(bus.cpu_readdatavalid), 32'd0);
        stepCycle();
        checkOutput("cpu_wr_no_rdv_b", 32'(bus.cpu_readdatavalid), 32'd0);
    endtask

    task automatic cpuRead(input logic [ADDR_W-1:0] a);
        applyStimulus(randJdo(), 1'b0, 1'b0, 1'b0, a, 1'b1, 1'b0, $urandom, 4'($urandom));
        waitAccept("cpu_rd");
        driveIdle();
        checkOutput("cpu_rd_cs_we", 32'({bus.ram_cs, bus.ram_we}), 32'd2);
        checkOutput("cpu_rd_addr", 32'(bus.ram_addr), 32'(a));
        stepCycle();
        checkOutput("cpu_rd_rdv_early", 32'(bus.cpu_readdatavalid), 32'd0);
        stepCycle();
        checkOutput("cpu_rd_rdv", 32'(bus.cpu_readdatavalid), 32'd1);
        checkOutput("cpu_rd_data", bus.cpu_readdata, ref_mem[a]);
        stepCycle();
        checkOutput("cpu_rd_rdv_pulse", 32'(bus.cpu_readdatavalid), 32'd0);
    endtask

    task automatic jtagLoad(input logic [ADDR_W-1:0] a);
        logic [37:0] j;
        j = randJdo();
        j[ADDR_W+16:17] = a;
        applyStimulus(j, 1'b1, 1'b0, 1'b0, ADDR_W'($urandom), 1'b0, 1'b0, $urandom, 4'($urandom));
        stepCycle();
        driveIdle();
        model_jaddr = a;
        checkOutput("jtag_load_busy", 32'(bus.jtag_busy), 32'd0);
        checkOutput("jtag_load_mrdy", 32'(bus.monitor_ready), 32'd0);
    endtask

    task automatic jtagWrite(input logic [31:0] d);
        logic [37:0] j;
        int n;
        j = randJdo();
        j[34:3] = d;
        applyStimulus(j, 1'b0, 1'b0, 1'b1, ADDR_W'($urandom), 1'b0, 1'b0, $urandom, 4'($urandom));
        stepCycle();
        driveIdle();
        checkOutput("jtag_wr_busy", 32'(bus.jtag_busy), 32'd1);
        n = 0;
        while (bus.jtag_busy && n < 20) begin
            stepCycle();
            n++;
        end
        checkOutput("jtag_wr_latency", 32'(n), 32'd2);
        ref_mem[model_jaddr] = d;
        model_jaddr = model_jaddr + 1'b1;
    endtask

    task automatic jtagRead(output logic [31:0] got);
        int n;
        applyStimulus(randJdo(), 1'b0, 1'b1, 1'b0, ADDR_W'($urandom), 1'b0, 1'b0, $urandom, 4'($urandom));
        stepCycle();
        driveIdle();
        checkOutput("jtag_rd_busy", 32'(bus.jtag_busy), 32'd1);
        checkOutput("jtag_rd_mrdy_clear", 32'(bus.monitor_ready), 32'd0);
        n = 0;
        while (!bus.monitor_ready && n < 20) begin
            stepCycle();
            n++;
        end
        checkOutput("jtag_rd_latency", 32'(n), 32'd3);
        checkOutput("jtag_rd_data", bus.MonDReg, ref_mem[model_jaddr]);
        checkOutput("jtag_rd_busy_done", 32'(bus.jtag_busy), 32'd0);
        got = bus.MonDReg;
        model_jaddr = model_jaddr + 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [37:0] j;
        logic [31:0] got;
        int          base;
        int          op;

        // Power-on reset
        reset     = 1'b1;
        ram_clear = 1'b1;
        driveIdle();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        model_jaddr = '0;
        repeat (3) begin
            stepCycle();
            checkResetState("por");
        end
        reset     = 1'b0;
        ram_clear = 1'b0;
        stepCycle();

        // Tie from reset: CPU first, then JTAG, then CPU again
        jtagLoad(8'h40);
        base = wlog_addr.size();
        j = randJdo();
        j[34:3] = 32'hA5A5_0001;
        applyStimulus(j, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 32'h0, 4'h0);
        stepCycle();
        applyStimulus(randJdo(), 1'b0, 1'b0, 1'b0, 8'h20, 1'b0, 1'b1, 32'h0C0C_0001, 4'hF);
        #1;
        checkOutput("tie_cpu_first_wait", 32'(bus.cpu_waitrequest), 32'd0);
        checkOutput("tie_jtag_pending", 32'(bus.jtag_busy), 32'd1);
        @(posedge clk); #1;
        applyStimulus(randJdo(), 1'b0, 1'b0, 1'b0, 8'h21, 1'b0, 1'b1, 32'h0C0C_0002, 4'hF);
        #1;
        checkOutput("tie_acc_wait", 32'(bus.cpu_waitrequest), 32'd1);
        @(posedge clk); #2;
        checkOutput("tie_jtag_second_wait", 32'(bus.cpu_waitrequest), 32'd1);
        @(posedge clk); #1;
        checkOutput("tie_jtag_ram_addr", 32'(bus.ram_addr), 32'h40);
        checkOutput("tie_jtag_ram_we", 32'({bus.ram_cs, bus.ram_we}), 32'd3);
        @(posedge clk); #2;
        checkOutput("tie_cpu_third_wait", 32'(bus.cpu_waitrequest), 32'd0);
        checkOutput("tie_jtag_done", 32'(bus.jtag_busy), 32'd0);
        @(posedge clk); #1;
        driveIdle();
        stepCycle();
        checkOutput("tie_write_count", 32'(wlog_addr.size() - base), 32'd3);
        if (wlog_addr.size() >= base + 3) begin
            checkOutput("tie_order_1", {wlog_data[base], 24'h0, wlog_addr[base]} == {32'h0C0C_0001, 32'h20}, 1);
            checkOutput("tie_order_2", {wlog_data[base+1], 24'h0, wlog_addr[base+1]} == {32'hA5A5_0001, 32'h40}, 1);
            checkOutput("tie_order_3", {wlog_data[base+2], 24'h0, wlog_addr[base+2]} == {32'h0C0C_0002, 32'h21}, 1);
        end
        ref_mem[8'h20] = 32'h0C0C_0001;
        ref_mem[8'h40] = 32'hA5A5_0001;
        ref_mem[8'h21] = 32'h0C0C_0002;
        model_jaddr    = 8'h41;

        // CPU write then read back
        cpuWrite(8'h10, 32'hDEAD_BEEF, 4'hF, 1'b0);
        cpuRead(8'h10);
        checkOutput("cpu_deadbeef", bus.cpu_readdata, 32'hDEAD_BEEF);

        // JTAG sequence with address wrap
        jtagLoad(8'hFF);
        jtagWrite(32'h1234_5678);
        jtagWrite(32'h9ABC_DEF0);
        checkOutput("jtag_wrap_addr", 32'(wlog_addr[$]), 32'h0);
        jtagLoad(8'hFF);
        jtagRead(got);
        checkOutput("jtag_read_ff", got, 32'h1234_5678);
        checkOutput("jtag_read_ff_mrdy", 32'(bus.monitor_ready), 32'd1);
        jtagRead(got);
        checkOutput("jtag_read_00", got, 32'h9ABC_DEF0);
        checkOutput("jtag_read_00_mrdy", 32'(bus.monitor_ready), 32'd1);

        // Overrun: second write strobe one cycle after the first
        base = ram_wr_count;
        j = randJdo();
        j[34:3] = 32'h1111_2222;
        applyStimulus(j, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 32'h0, 4'h0);
        stepCycle();
        j = randJdo();
        j[34:3] = 32'h3333_4444;
        applyStimulus(j, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 32'h0, 4'h0);
        stepCycle();
        driveIdle();
        checkOutput("ovr_flag", 32'(bus.jtag_overrun), 32'd1);
        repeat (4) stepCycle();
        checkOutput("ovr_ram_writes", 32'(ram_wr_count - base), 32'd1);
        ref_mem[model_jaddr] = 32'h1111_2222;
        model_jaddr = model_jaddr + 1'b1;
        cpuRead(model_jaddr - 1'b1);
        checkOutput("ovr_sticky", 32'(bus.jtag_overrun), 32'd1);

        // Reset in the middle of a CPU read
        applyStimulus(randJdo(), 1'b0, 1'b0, 1'b0, 8'h10, 1'b1, 1'b0, 32'h0, 4'h0);
        waitAccept("rst_rd");
        reset = 1'b1;
        driveIdle();
        #1;
        checkOutput("rst_wait_comb", 32'(bus.cpu_waitrequest), 32'd1);
        repeat (3) begin
            stepCycle();
            checkResetState("mid_rst");
        end
        reset = 1'b0;
        model_jaddr = '0;
        repeat (4) begin
            stepCycle();
            checkOutput("rst_no_rdv", 32'(bus.cpu_readdatavalid), 32'd0);
        end

        // Randomized mix of CPU and JTAG transactions
        for (int it = 0; it < 150; it++) begin
            op = $urandom_range(0, 5);
            case (op)
                0, 1: cpuWrite(ADDR_W'($urandom), $urandom, 4'($urandom), ($urandom_range(0, 3) == 0));
                2:    cpuRead(ADDR_W'($urandom));
                3:    jtagLoad(ADDR_W'($urandom));
                4:    jtagWrite($urandom);
                default: jtagRead(got);
            endcase
            repeat ($urandom_range(0, 2)) stepCycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
